dm_access_unit: RTL

- Data-memory stage engine sitting on the output side of ex_dm_register.
- Consumes m_alu_y (effective address) and memory controls, and runs a single-outstanding req/ack transaction on the data bus.
- Holds the pipeline via stall while the access is in flight.
- Returns the aligned, sign/zero-extended load data toward writeback.

---
 rtl/dm_access_unit_if.sv | 22 ++
 rtl/dm_access_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit_if.sv
// Data-bus interface between dm_access_unit (master) and the data memory (slave).
// Single-outstanding req/ack protocol: req is held until a one-cycle ack,
// and address, byte enables, write data and we stay stable while req is high.
interface dm_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dm_access_unit.sv
// Data-memory stage engine: runs one req/ack transaction per load/store taken
// from ex_dm_register, stalls the pipeline while it is in flight, aborts with
// bus_err after TIMEOUT_CYCLES busy cycles without ack, and returns the
// lane-selected, sign/zero-extended load data.
// Optional macro DM_MISALIGN_TRAP_EN: misaligned H/W accesses are blocked and
// reported on the extra 'misalign' output instead of reaching the bus.
module dm_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m_valid,
    input  logic [31:0]              m_alu_y,
    input  logic [31:0]              m_wdata,
    input  logic                     m_mem_read,
    input  logic                     m_mem_write,
    input  logic [2:0]               m_funct3,
    output logic                     stall,
    dm_access_unit_if.master         bus,
    output logic [31:0]              w_rdata,
    output logic                     w_valid,
    output logic                     bus_err
`ifdef DM_MISALIGN_TRAP_EN
    ,
    output logic                     misalign
`endif
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_w_rdata;
    logic        r_w_valid;
    logic        r_bus_err;
    logic [7:0]  r_cnt;
    logic        r_is_load;
    logic [1:0]  r_lane;
    logic [2:0]  r_funct3;
`ifdef DM_MISALIGN_TRAP_EN
    logic        r_misalign;
`endif

    logic        w_mem_op;
    logic        w_misalign_block;
    logic        w_start;
    logic        w_timeout;
    logic [1:0]  w_lane;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    // Request decode: lane, byte enables, replicated store data, start/block
    always_comb begin
        w_mem_op         = m_valid & (m_mem_read | m_mem_write);
        w_misalign_block = 1'b0;
        w_lane           = 2'b00;
        w_be             = 4'hF;
        w_wdata          = m_wdata;
        case (m_funct3)
            3'b000, 3'b100: begin
                w_lane  = m_alu_y[1:0];
                w_be    = 4'b0001 << m_alu_y[1:0];
                w_wdata = {4{m_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                w_lane  = {m_alu_y[1], 1'b0};
                w_be    = 4'b0011 << {m_alu_y[1], 1'b0};
                w_wdata = {2{m_wdata[15:0]}};
`ifdef DM_MISALIGN_TRAP_EN
                w_misalign_block = w_mem_op & m_alu_y[0];
`endif
            end
            default: begin
`ifdef DM_MISALIGN_TRAP_EN
                if (m_funct3 == 3'b010) begin
                    w_misalign_block = w_mem_op & (m_alu_y[1:0] != 2'b00);
                end
`endif
            end
        endcase
        w_start   = w_mem_op & ~w_misalign_block;
        w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));
    end

    // Load extension from the registered lane and size of the access in flight
    always_comb begin
        w_shifted   = bus.bus_rdata >> {r_lane, 3'b000};
        w_load_data = bus.bus_rdata;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_data = {24'h000000, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_data = {16'h0000, w_shifted[15:0]};
            default: w_load_data = bus.bus_rdata;
        endcase
    end

    // Next-state and stall; stall is forced low while reset is asserted
    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = BUSY;
                    stall        = 1'b1;
                end
            end
            BUSY: begin
                if (bus.bus_ack || w_timeout) begin
                    w_next_state = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (!reset) begin
            stall = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bus request, timeout counter and writeback registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_w_rdata   <= '0;
            r_w_valid   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_cnt       <= '0;
            r_is_load   <= 1'b0;
            r_lane      <= '0;
            r_funct3    <= '0;
`ifdef DM_MISALIGN_TRAP_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            r_w_valid <= 1'b0;
            r_bus_err <= 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
            r_misalign <= (r_state == IDLE) & w_misalign_block;
`endif
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= ~m_mem_read;
                        r_bus_addr  <= {m_alu_y[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_cnt       <= '0;
                        r_is_load   <= m_mem_read;
                        r_lane      <= w_lane;
                        r_funct3    <= m_funct3;
                    end
                end
                BUSY: begin
                    if (bus.bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_w_valid <= 1'b1;
                        if (r_is_load) begin
                            r_w_rdata <= w_load_data;
                        end
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_be    = r_bus_be;
    assign bus.bus_wdata = r_bus_wdata;
    assign w_rdata       = r_w_rdata;
    assign w_valid       = r_w_valid;
    assign bus_err       = r_bus_err;
`ifdef DM_MISALIGN_TRAP_EN
    assign misalign      = r_misalign;
`endif

endmodule
